// File: rtl/gate_scan_pkg.sv
// Shared types and reference truth tables for the gate scanner.
// Library cell tables are indexed by pattern {b,a}.
package gate_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } scan_state_e;

    localparam logic [3:0] NAND2 = 4'b0111;
    localparam logic [3:0] AND2  = 4'b1000;
    localparam logic [3:0] OR2   = 4'b1110;
    localparam logic [3:0] NOR2  = 4'b0001;
    localparam logic [3:0] XOR2  = 4'b0110;
    localparam logic [3:0] XNOR2 = 4'b1001;

endpackage

// File: rtl/scan_settle_timer.sv
// Settle-interval counter for the gate scanner.
// expire flags the last cycle of the hold interval.
module scan_settle_timer
    import gate_scan_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign expire = (cnt == 4'(SETTLE - 1));

endmodule

// File: rtl/gate_truth_table_scanner.sv
// Walks every input pattern of a combinational gate, records its
// truth table and compares it with a latched expected table.
module gate_truth_table_scanner
    import gate_scan_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        gate_in,
    input  logic                   gate_out,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   truth_table,
    output logic                   pass,
    output logic [N_IN:0]          mismatch_cnt,
    output logic [N_IN-1:0]        mismatch_idx
);

    localparam int NP = 1 << N_IN;

    scan_state_e     state, state_d;
    logic [NP-1:0]   exp_q, exp_d;
    logic [NP-1:0]   table_d;
    logic [NP-1:0]   diff;
    logic [N_IN-1:0] gate_in_d;
    logic [N_IN-1:0] low_idx;
    logic [N_IN-1:0] midx_d;
    logic [N_IN:0]   pop;
    logic [N_IN:0]   mcnt_d;
    logic            busy_d;
    logic            done_d;
    logic            pass_d;
    logic            found;
    logic            tmr_clear;
    logic            tmr_en;
    logic            expire;

    scan_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .expire (expire)
    );

    always_comb begin
        diff    = truth_table ^ exp_q;
        pop     = '0;
        low_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NP; i++) begin
            if (diff[i]) begin
                pop = pop + (N_IN+1)'(1);
                if (!found) begin
                    low_idx = N_IN'(i);
                end
                found = 1'b1;
            end
        end
    end

    // gate_in doubles as the current pattern index
    always_comb begin
        state_d   = state;
        exp_d     = exp_q;
        table_d   = truth_table;
        gate_in_d = gate_in;
        busy_d    = busy;
        done_d    = 1'b0;
        pass_d    = pass;
        mcnt_d    = mismatch_cnt;
        midx_d    = mismatch_idx;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    exp_d     = expected;
                    table_d   = '0;
                    mcnt_d    = '0;
                    pass_d    = 1'b0;
                    gate_in_d = '0;
                    busy_d    = 1'b1;
                    tmr_clear = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                tmr_en = 1'b1;
                if (expire) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                table_d[gate_in] = gate_out;
                if (gate_in == N_IN'(NP - 1)) begin
                    state_d = FINISH;
                end else begin
                    gate_in_d = gate_in + N_IN'(1);
                    tmr_clear = 1'b1;
                    state_d   = WAIT;
                end
            end
            FINISH: begin
                pass_d  = (truth_table == exp_q);
                mcnt_d  = pop;
                midx_d  = low_idx;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            exp_q        <= '0;
            truth_table  <= '0;
            gate_in      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            mismatch_idx <= '0;
        end else begin
            state        <= state_d;
            exp_q        <= exp_d;
            truth_table  <= table_d;
            gate_in      <= gate_in_d;
            busy         <= busy_d;
            done         <= done_d;
            pass         <= pass_d;
            mismatch_cnt <= mcnt_d;
            mismatch_idx <= midx_d;
        end
    end

endmodule

// File: tb/tb_gate_truth_table_scanner.sv
// Randomised bench for gate_truth_table_scanner with a
// scan-level reference model and per-cycle output comparison.
module tb_gate_truth_table_scanner;
    import gate_scan_pkg::*;

    localparam int NP = 4;
    localparam int P  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] expected = '0;
    logic [1:0] gate_in;
    logic       gate_out;
    logic       busy, done, pass;
    logic [3:0] truth_table;
    logic [2:0] mismatch_cnt;
    logic [1:0] mismatch_idx;
    logic [3:0] lut = NAND2;

    logic       start1 = 1'b0;
    logic [1:0] expected1 = 2'b01;
    logic [0:0] gate_in1;
    logic       gate_out1;
    logic       busy1, done1, pass1;
    logic [1:0] table1;
    logic [1:0] mcnt1;
    logic [0:0] midx1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign gate_out  = lut[gate_in];
    assign gate_out1 = ~gate_in1[0];

    gate_truth_table_scanner #(.N_IN(2), .SETTLE(2)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected),
        .gate_in(gate_in), .gate_out(gate_out), .busy(busy), .done(done),
        .truth_table(truth_table), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .mismatch_idx(mismatch_idx)
    );

    gate_truth_table_scanner #(.N_IN(1), .SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected1),
        .gate_in(gate_in1), .gate_out(gate_out1), .busy(busy1), .done(done1),
        .truth_table(table1), .pass(pass1),
        .mismatch_cnt(mcnt1), .mismatch_idx(midx1)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: k counts edges since acceptance; pattern p is sampled at k=(p+1)*P
    int         k = 0;
    logic       m_busy = 0, m_done = 0, m_pass = 0;
    logic [3:0] m_table = '0, m_exp = '0;
    logic [1:0] m_gate_in = '0, m_idx = '0;
    logic [2:0] m_cnt = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0; m_busy = 0; m_done = 0; m_pass = 0;
            m_table = '0; m_exp = '0; m_gate_in = '0;
            m_idx = '0; m_cnt = '0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                k++;
                if (k % P == 0 && k / P <= NP) begin
                    m_table[k/P-1] = lut[m_gate_in];
                    if (k / P < NP) m_gate_in = 2'(k / P);
                end
                if (k == NP * P + 1) begin
                    m_busy = 0;
                    m_done = 1;
                    m_pass = (m_table == m_exp);
                    m_cnt  = 3'($countones(m_table ^ m_exp));
                    m_idx  = '0;
                    for (int i = NP - 1; i >= 0; i--)
                        if (m_table[i] != m_exp[i]) m_idx = 2'(i);
                end
            end else if (start) begin
                k = 0; m_busy = 1; m_exp = expected;
                m_table = '0; m_pass = 0; m_cnt = '0; m_gate_in = '0;
            end
        end
    end

    always @(negedge clk) begin
        check("gate_in", 32'(gate_in), 32'(m_gate_in));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("table", 32'(truth_table), 32'(m_table));
        check("pass", 32'(pass), 32'(m_pass));
        check("mcnt", 32'(mismatch_cnt), 32'(m_cnt));
        check("midx", 32'(mismatch_idx), 32'(m_idx));
    end

    task automatic launch(input logic [3:0] exp);
        start = 1'b1;
        expected = exp;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int poke, output int e);
        e = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            start = (i == poke - 1);
            expected = 4'($urandom);
            if (done) begin
                e = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int e;
        int dcount;
        repeat (2) @(negedge clk);
        check("rst_outs", 32'({busy, done, pass, truth_table, gate_in,
                               mismatch_cnt, mismatch_idx}), 32'(0));
        rst_n = 1'b1;

        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        e = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done1) begin
                e = i;
                break;
            end
        end
        check("inv_lat", 32'(e), 32'(5));
        check("inv_table", 32'(table1), 32'(2'b01));
        check("inv_pass", 32'(pass1), 32'(1));

        @(negedge clk);
        lut = NAND2;
        launch(NAND2);
        wait_done(0, e);
        check("nand_lat", 32'(e), 32'(13));
        @(negedge clk);
        check("nand_res", 32'({truth_table, pass, mismatch_cnt, mismatch_idx}),
              32'({4'b0111, 1'b1, 3'd0, 2'd0}));

        launch(AND2);
        wait_done(0, e);
        check("and_lat", 32'(e), 32'(13));
        @(negedge clk);
        check("and_res", 32'({truth_table, pass, mismatch_cnt, mismatch_idx}),
              32'({4'b0111, 1'b0, 3'd4, 2'd0}));

        lut = 4'b1111;
        launch(NAND2);
        wait_done(0, e);
        @(negedge clk);
        check("tie1_res", 32'({truth_table, pass, mismatch_cnt, mismatch_idx}),
              32'({4'b1111, 1'b0, 3'd1, 2'd3}));

        lut = NAND2;
        launch(NAND2);
        wait_done(4, e);
        check("poke_lat", 32'(e), 32'(13));
        launch(XOR2);
        wait_done(0, e);
        check("again_lat", 32'(e), 32'(13));
        @(negedge clk);
        check("again_pass", 32'(pass), 32'(0));

        launch(NAND2);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst", 32'({busy, done, pass, truth_table, gate_in,
                             mismatch_cnt, mismatch_idx}), 32'(0));
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check("midrst_nodone", 32'(dcount), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch(NAND2);
        wait_done(0, e);
        check("post_lat", 32'(e), 32'(13));
        @(negedge clk);
        check("post_pass", 32'(pass), 32'(1));

        for (int n = 0; n < 20; n++) begin
            lut = 4'($urandom);
            @(negedge clk);
            launch(4'($urandom));
            wait_done(($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 12)) : 0, e);
            check("rand_lat", 32'(e), 32'(13));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
